// File: rtl/stepper_sequencer.sv
// Two-coil stepper sequencer: bipolar H-bridge or unipolar coil drive, half/full
// stepping, walk-to-run ramp, all-off dead time before each phase change, position count.
module stepper_sequencer #(
  parameter int CNT_WIDTH  = 32,
  parameter int POS_WIDTH  = 32,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_unipolar,
  input  logic                 i_go,
  input  logic                 i_stop,
  input  logic                 i_full_step,
  input  logic                 i_half_step,
  input  logic                 i_continuous,
  input  logic                 i_direction,
  input  logic                 i_hold_en,
  input  logic [POS_WIDTH-1:0] i_steps,
  input  logic [CNT_WIDTH-1:0] i_walk_period,
  input  logic [CNT_WIDTH-1:0] i_run_period,
  input  logic [CNT_WIDTH-1:0] i_accel,
  input  logic [CNT_WIDTH-1:0] i_dead_period,
  output logic                 o_busy,
  output logic                 o_err_bad_step,
  output logic [POS_WIDTH-1:0] o_steps_left,
  output logic [POS_WIDTH-1:0] o_curr_pos,
  output logic [3:0]           o_drive
);

  // state   | meaning
  // IDLE    | no move; drive is the held phase (if enabled) or all-off
  // DEAD    | all-off gap before the next phase change
  // HOLD    | new phase energised for the current step period
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DEAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [POS_WIDTH-1:0] POS_ONE = {{(POS_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic [POS_WIDTH-1:0] steps_left_q, steps_left_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic                 half_q, half_d;
  logic                 dir_q, dir_d;
  logic                 cont_q, cont_d;
  logic                 stop_q, stop_d;
  logic                 err_q, err_d;
  logic                 held_q, held_d;

  logic                 go_ok;
  logic                 move_done;
  logic [2:0]           idx_next;
  logic [1:0]           quad_next;
  logic [CNT_WIDTH-1:0] dead_len_m1;
  logic [CNT_WIDTH-1:0] hold_len_m1;
  logic [CNT_WIDTH-1:0] start_period;
  logic [CNT_WIDTH-1:0] ramp_period;
  logic [CNT_WIDTH:0]   ramp_diff;

  assign go_ok = (i_full_step ^ i_half_step) && ((i_steps != '0) || i_continuous);

  // Timers count down to zero, so load length-1 with a floor of one cycle.
  assign dead_len_m1  = (i_dead_period == '0) ? '0 : i_dead_period - CNT_ONE;
  assign hold_len_m1  = (period_q == '0) ? '0 : period_q - CNT_ONE;
  assign start_period = (i_walk_period > i_run_period) ? i_walk_period : i_run_period;

  assign ramp_diff   = {1'b0, period_q} - {1'b0, i_accel};
  assign ramp_period = (ramp_diff[CNT_WIDTH] || (ramp_diff[CNT_WIDTH-1:0] < i_run_period))
                       ? i_run_period : ramp_diff[CNT_WIDTH-1:0];

  // Full steps snap to even indices and move a whole quadrant.
  assign quad_next = dir_q ? (idx_q[2:1] + 2'd1) : (idx_q[2:1] - 2'd1);
  assign idx_next  = half_q ? (dir_q ? (idx_q + 3'd1) : (idx_q - 3'd1)) : {quad_next, 1'b0};

  assign move_done = stop_q || i_stop || (!cont_q && (steps_left_q == '0));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pos_d        = pos_q;
    steps_left_d = steps_left_q;
    period_d     = period_q;
    timer_d      = timer_q;
    half_d       = half_q;
    dir_d        = dir_q;
    cont_d       = cont_q;
    stop_d       = stop_q;
    err_d        = 1'b0;
    held_d       = held_q;

    if ((state_q != ST_IDLE) && i_stop) begin
      stop_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (i_go) begin
          if (go_ok) begin
            state_d      = ST_DEAD;
            steps_left_d = i_steps;
            period_d     = start_period;
            timer_d      = dead_len_m1;
            half_d       = i_half_step;
            dir_d        = i_direction;
            cont_d       = i_continuous;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DEAD: begin
        if (timer_q == '0) begin
          state_d = ST_HOLD;
          idx_d   = idx_next;
          pos_d   = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
          held_d  = 1'b1;
          timer_d = hold_len_m1;
          if (!cont_q) begin
            steps_left_d = steps_left_q - POS_ONE;
          end
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (timer_q == '0) begin
          if (move_done) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d  = ST_DEAD;
            period_d = ramp_period;
            timer_d  = dead_len_m1;
          end
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      pos_q        <= '0;
      steps_left_q <= '0;
      period_q     <= '0;
      timer_q      <= '0;
      half_q       <= 1'b0;
      dir_q        <= 1'b0;
      cont_q       <= 1'b0;
      stop_q       <= 1'b0;
      err_q        <= 1'b0;
      held_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pos_q        <= pos_d;
      steps_left_q <= steps_left_d;
      period_q     <= period_d;
      timer_q      <= timer_d;
      half_q       <= half_d;
      dir_q        <= dir_d;
      cont_q       <= cont_d;
      stop_q       <= stop_d;
      err_q        <= err_d;
      held_q       <= held_d;
    end
  end

  logic       a_pos, a_neg, b_pos, b_neg;
  logic [3:0] phase_map;
  logic [3:0] drive_raw;

  always_comb begin
    a_pos = 1'b0;
    a_neg = 1'b0;
    b_pos = 1'b0;
    b_neg = 1'b0;
    case (idx_q)
      3'd0: a_pos = 1'b1;
      3'd1: begin a_pos = 1'b1; b_pos = 1'b1; end
      3'd2: b_pos = 1'b1;
      3'd3: begin a_neg = 1'b1; b_pos = 1'b1; end
      3'd4: a_neg = 1'b1;
      3'd5: begin a_neg = 1'b1; b_neg = 1'b1; end
      3'd6: b_neg = 1'b1;
      default: begin a_pos = 1'b1; b_neg = 1'b1; end
    endcase
  end

  // held_q keeps a freshly reset block all-off even with hold enabled.
  assign phase_map = i_unipolar ? {b_neg, a_neg, b_pos, a_pos} : {b_neg, b_pos, a_neg, a_pos};
  assign drive_raw = ((state_q == ST_HOLD) || ((state_q == ST_IDLE) && i_hold_en && held_q))
                     ? phase_map : 4'b0000;

  assign o_drive        = ACTIVE_LOW ? ~drive_raw : drive_raw;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_err_bad_step = err_q;
  assign o_steps_left   = steps_left_q;
  assign o_curr_pos     = pos_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Bench for stepper_sequencer: directed and random moves checked cycle by cycle
// against a step-list model; a second instance checks the ACTIVE_LOW output.
module tb_stepper_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_unipolar, i_go, i_stop, i_full_step, i_half_step;
  logic        i_continuous, i_direction, i_hold_en;
  logic [31:0] i_steps, i_walk_period, i_run_period, i_accel, i_dead_period;

  logic        busy0, err0, busy1, err1;
  logic [31:0] sl0, pos0, sl1, pos1;
  logic [3:0]  drv0, drv1;

  int n_cmp = 0;
  int n_bad = 0;

  // model state carried between moves
  logic [2:0]  m_idx;
  logic [31:0] m_pos;
  logic        m_held;

  always #5 clk = ~clk;

  stepper_sequencer #(.CNT_WIDTH(32), .POS_WIDTH(32), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .i_unipolar(i_unipolar), .i_go(i_go), .i_stop(i_stop),
    .i_full_step(i_full_step), .i_half_step(i_half_step), .i_continuous(i_continuous),
    .i_direction(i_direction), .i_hold_en(i_hold_en), .i_steps(i_steps),
    .i_walk_period(i_walk_period), .i_run_period(i_run_period), .i_accel(i_accel),
    .i_dead_period(i_dead_period), .o_busy(busy0), .o_err_bad_step(err0),
    .o_steps_left(sl0), .o_curr_pos(pos0), .o_drive(drv0));

  stepper_sequencer #(.CNT_WIDTH(32), .POS_WIDTH(32), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .i_unipolar(i_unipolar), .i_go(i_go), .i_stop(i_stop),
    .i_full_step(i_full_step), .i_half_step(i_half_step), .i_continuous(i_continuous),
    .i_direction(i_direction), .i_hold_en(i_hold_en), .i_steps(i_steps),
    .i_walk_period(i_walk_period), .i_run_period(i_run_period), .i_accel(i_accel),
    .i_dead_period(i_dead_period), .o_busy(busy1), .o_err_bad_step(err1),
    .o_steps_left(sl1), .o_curr_pos(pos1), .o_drive(drv1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Windings from the electrical angle (index * 45 degrees).
  function automatic logic [3:0] exp_drive(input logic [2:0] idx, input logic uni);
    int deg;
    logic ap, an, bp, bn;
    deg = int'(idx) * 45;
    ap = (deg >= 315) || (deg <= 45);
    an = (deg >= 135) && (deg <= 225);
    bp = (deg >= 45) && (deg <= 135);
    bn = (deg >= 225) && (deg <= 315);
    return uni ? {bn, an, bp, ap} : {bn, bp, an, ap};
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic half, input logic dir);
    int i;
    if (half) i = (int'(idx) + (dir ? 1 : 7)) % 8;
    else      i = ((int'(idx) / 2 + (dir ? 1 : 3)) % 4) * 2;
    return 3'(i);
  endfunction

  // Build the expected {busy, drive} per cycle as a list of steps, then replay it.
  task automatic run_move(input logic uni, input logic half, input logic cont, input logic dir,
                          input logic hold, input logic [31:0] steps, input logic [31:0] walk,
                          input logic [31:0] run, input logic [31:0] accel, input logic [31:0] dead,
                          input int stop_at, input int rego_at, input logic stop_with_go);
    logic [4:0]  expq[$];
    logic [3:0]  idle_drv;
    longint      p, dl, hl, t;
    logic [31:0] sl;
    bit          done;
    int          movelen;
    i_unipolar = uni; i_half_step = half; i_full_step = ~half; i_continuous = cont;
    i_direction = dir; i_hold_en = hold; i_steps = steps; i_walk_period = walk;
    i_run_period = run; i_accel = accel; i_dead_period = dead;
    i_go = 1'b1; i_stop = stop_with_go;

    p = (walk > run) ? longint'(walk) : longint'(run);
    sl = steps; t = 0; done = 1'b0;
    while (!done) begin
      dl = (dead == 0) ? 1 : longint'(dead);
      hl = (p == 0) ? 1 : p;
      for (longint i = 0; i < dl; i++) expq.push_back(5'b10000);
      m_idx = next_idx(m_idx, half, dir);
      m_pos = dir ? m_pos + 32'd1 : m_pos - 32'd1;
      if (!cont) sl = sl - 32'd1;
      m_held = 1'b1;
      for (longint i = 0; i < hl; i++) expq.push_back({1'b1, exp_drive(m_idx, uni)});
      t += dl + hl;
      if ((stop_at >= 0 && longint'(stop_at) < t) || (!cont && sl == 0)) done = 1'b1;
      else if (longint'(accel) > p || p - longint'(accel) < longint'(run)) p = longint'(run);
      else p = p - longint'(accel);
    end
    movelen = expq.size();
    idle_drv = (hold && m_held) ? exp_drive(m_idx, uni) : 4'b0000;
    expq.push_back({1'b0, idle_drv});
    expq.push_back({1'b0, idle_drv});
    if (rego_at >= movelen) rego_at = -1;

    @(negedge clk);
    i_go = 1'b0; i_stop = 1'b0;
    chk("err_on_go", {31'd0, err0}, 32'd0);
    // mode/direction changes after go must not affect the move
    i_direction = 1'($urandom_range(0, 1));
    i_half_step = 1'($urandom_range(0, 1));
    i_full_step = 1'($urandom_range(0, 1));
    for (int c = 0; c < expq.size(); c++) begin
      chk("busy", {31'd0, busy0}, {31'd0, expq[c][4]});
      chk("drive", {28'd0, drv0}, {28'd0, expq[c][3:0]});
      chk("drive_al", {28'd0, drv1}, {28'd0, ~expq[c][3:0]});
      chk("err_quiet", {31'd0, err0}, 32'd0);
      i_stop = (c == stop_at);
      i_go = (c == rego_at);
      @(negedge clk);
    end
    i_stop = 1'b0; i_go = 1'b0;
    chk("pos", pos0, m_pos);
    chk("pos_al", pos1, m_pos);
    chk("steps_left", sl0, cont ? steps : sl);
  endtask

  task automatic bad_go(input logic full, input logic half, input logic cont, input logic [31:0] steps);
    logic [3:0] idle_drv;
    i_full_step = full; i_half_step = half; i_continuous = cont; i_steps = steps;
    i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    chk("err_pulse", {31'd0, err0}, 32'd1);
    chk("err_pulse_al", {31'd0, err1}, 32'd1);
    chk("err_busy", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    idle_drv = (i_hold_en && m_held) ? exp_drive(m_idx, i_unipolar) : 4'b0000;
    chk("err_single", {31'd0, err0}, 32'd0);
    chk("err_busy2", {31'd0, busy0}, 32'd0);
    chk("err_idle_drv", {28'd0, drv0}, {28'd0, idle_drv});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_idx = 3'd0; m_pos = 32'd0; m_held = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] steps_r;
    logic        cont_r;
    int          stop_r;
    rst = 1'b1;
    i_unipolar = 1'b0; i_go = 1'b0; i_stop = 1'b0; i_full_step = 1'b0; i_half_step = 1'b0;
    i_continuous = 1'b0; i_direction = 1'b0; i_hold_en = 1'b1; i_steps = '0;
    i_walk_period = '0; i_run_period = '0; i_accel = '0; i_dead_period = '0;
    m_idx = 3'd0; m_pos = 32'd0; m_held = 1'b0;
    #3;
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_drive", {28'd0, drv0}, 32'd0);
    chk("rst_drive_al", {28'd0, drv1}, 32'hF);
    chk("rst_pos", pos0, 32'd0);
    chk("rst_steps", sl0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // half step forward, three steps
    run_move(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 32'd4, 32'd4, 32'd0, 32'd2, -1, -1, 1'b0);
    chk("pos_plus3", pos0, 32'd3);
    pulse_reset();
    // unipolar full step reverse from index 0
    run_move(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 32'd3, 32'd3, 32'd0, 32'd1, -1, -1, 1'b0);
    chk("pos_minus2", pos0, 32'hFFFFFFFE);
    // ramp 10, 7, 4, 4, 4
    run_move(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 32'd10, 32'd4, 32'd3, 32'd1, -1, -1, 1'b0);
    // continuous, stop during a DEAD phase, hold off then on
    run_move(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'd5, 32'd5, 32'd0, 32'd3, 9, -1, 1'b0);
    run_move(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd7, 32'd5, 32'd5, 32'd0, 32'd3, 1, 4, 1'b0);
    // go with a simultaneous stop in idle: go wins, stop is not latched
    run_move(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 32'd2, 32'd2, 32'd0, 32'd0, -1, 3, 1'b1);
    // invalid starts
    bad_go(1'b1, 1'b1, 1'b0, 32'd4);
    bad_go(1'b0, 1'b0, 1'b1, 32'd4);
    bad_go(1'b1, 1'b0, 1'b0, 32'd0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        bad_go(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 32'd0);
      end
      cont_r = ($urandom_range(0, 3) == 0);
      steps_r = cont_r ? 32'($urandom_range(0, 3)) : 32'($urandom_range(1, 6));
      stop_r = (cont_r || $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
      run_move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cont_r,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), steps_r,
               32'($urandom_range(0, 12)), 32'($urandom_range(0, 8)),
               32'($urandom_range(0, 5)), 32'($urandom_range(0, 3)),
               stop_r, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1, 1'b0);
    end

    // asynchronous reset in the middle of a HOLD
    i_unipolar = 1'b0; i_half_step = 1'b1; i_full_step = 1'b0; i_continuous = 1'b1;
    i_direction = 1'b1; i_hold_en = 1'b1; i_walk_period = 32'd20; i_run_period = 32'd20;
    i_accel = 32'd0; i_dead_period = 32'd2; i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy0}, 32'd1);
    chk("pre_rst_drive", {28'd0, drv0}, {28'd0, exp_drive(next_idx(m_idx, 1'b1, 1'b1), 1'b0)});
    #2 rst = 1'b1;
    #1;
    chk("async_drive_al", {28'd0, drv1}, 32'hF);
    chk("async_busy_al", {31'd0, busy1}, 32'd0);
    chk("async_drive", {28'd0, drv0}, 32'd0);
    chk("async_busy", {31'd0, busy0}, 32'd0);
    chk("async_pos", pos0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    i_continuous = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
